// File: rtl/alu_issue_fsm.sv
// alu_issue_fsm: multi-cycle issue/sequencing controller driving the KGP_RISC ALU.
// Optional macro ALU_ISSUE_ILLEGAL_TRAP_EN: an illegal instruction enters a sticky TRAP state left only by rst.
module alu_issue_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [2:0]  alu_opcode,
    output logic [3:0]  alu_fcode,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_sign,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [2:0]  flags,
    output logic        branch_taken,
    output logic [15:0] branch_offset,
    output logic        illegal,
    output logic        trap
);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, TRAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB} state_t;
`endif
    state_t      state_q;
    logic [31:0] instr_q;
    logic        legal_d;
    logic [31:0] in2_d;
    logic [2:0]  op_q;
    logic [3:0]  fc_q;
    logic [15:0] imm_q;
    logic        shift_q;
    logic        wb_en_q, br_q, illegal_q, trap_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] wb_data_q;
    logic [2:0]  flags_q;
    logic [15:0] br_off_q;

    assign op_q        = instr_q[31:29];
    assign fc_q        = instr_q[3:0];
    assign imm_q       = instr_q[19:4];
    assign shift_q     = fc_q == 4'd4 || fc_q == 4'd5 || fc_q == 4'd8;
    assign rs_addr     = instr_q[28:24];
    assign rt_addr     = instr_q[23:19];
    assign instr_ready = state_q == IDLE && !rst;
    assign wb_en         = wb_en_q;
    assign wb_addr       = wb_addr_q;
    assign wb_data       = wb_data_q;
    assign flags         = flags_q;
    assign branch_taken  = br_q;
    assign branch_offset = br_off_q;
    assign illegal       = illegal_q;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    // Legality of the incoming word and operand-2 selection for the latched instruction
    always_comb begin
        legal_d = instr[31:29] == 3'b000 ? instr[3:0] <= 4'd9 :
                  instr[31:29] == 3'b001 ? instr[3:0] <= 4'd1 :
                  instr[31:29] == 3'b101 ? instr[3:0] <= 4'd2 : 1'b0;
        in2_d   = op_q == 3'b001 ? {{16{imm_q[15]}}, imm_q} :
                  op_q == 3'b101 ? 32'd0 :
                  shift_q ? {27'd0, instr_q[18:14]} : rt_data;
    end

    // Issue FSM with all ALU controls and result/decision outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            alu_opcode <= '0;
            alu_fcode  <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            wb_en_q    <= 1'b0;
            br_q       <= 1'b0;
            illegal_q  <= 1'b0;
            trap_q     <= 1'b0;
            flags_q    <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            br_off_q   <= '0;
        end else begin
            wb_en_q   <= 1'b0;
            br_q      <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: if (instr_valid) begin
                    instr_q   <= instr;
                    illegal_q <= !legal_d;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                    trap_q    <= !legal_d;
                    state_q   <= legal_d ? DECODE : TRAP;
`else
                    state_q   <= DECODE;
`endif
                end
                DECODE: if (illegal_q) begin
                    state_q <= IDLE;
                end else begin
                    alu_opcode <= op_q;
                    alu_fcode  <= fc_q;
                    alu_in1    <= rs_data;
                    alu_in2    <= in2_d;
                    state_q    <= EXEC;
                end
                EXEC: begin
                    if (op_q == 3'b101) begin
                        br_q     <= fc_q == 4'd0 ? alu_sign : fc_q == 4'd1 ? alu_zero : !alu_zero;
                        br_off_q <= imm_q;
                    end else begin
                        wb_en_q   <= 1'b1;
                        wb_addr_q <= rs_addr;
                        wb_data_q <= alu_out;
                        flags_q   <= {alu_carry, alu_zero, alu_sign};
                    end
                    state_q <= WB;
                end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                TRAP: state_q <= TRAP;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_fsm.sv
// tb_alu_issue_fsm: directed bench for alu_issue_fsm with a stub register file and ALU.
module tb_alu_issue_fsm;
    logic        clk = 0, rst = 1;
    logic [31:0] instr = 0;
    logic        instr_valid = 0;
    logic        instr_ready;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic [2:0]  alu_opcode;
    logic [3:0]  alu_fcode;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        alu_carry, alu_zero, alu_sign;
    logic        wb_en, branch_taken, illegal, trap;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [2:0]  flags;
    logic [15:0] branch_offset;
    logic [31:0] regs [32];
    int vec = 0, miss = 0;

    localparam logic [31:0] ADD  = {3'b000, 5'd1, 5'd2, 5'd0, 10'd0, 4'd3};
    localparam logic [31:0] SHLL = {3'b000, 5'd3, 5'd0, 5'd31, 10'd0, 4'd4};
    localparam logic [31:0] ADDI = {3'b001, 5'd4, 4'd0, 16'hFFFF, 4'd0};
    localparam logic [31:0] BZ   = {3'b101, 5'd5, 4'd0, 16'h0010, 4'd1};
    localparam logic [31:0] BNZ  = {3'b101, 5'd5, 4'd0, 16'h0020, 4'd2};
    localparam logic [31:0] BAD  = 32'h6000_0000;

    alu_issue_fsm dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .alu_opcode(alu_opcode), .alu_fcode(alu_fcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flags(flags),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .illegal(illegal), .trap(trap)
    );

    always #5 clk = ~clk;
    assign rs_data = regs[rs_addr];
    assign rt_data = regs[rt_addr];

    // Stub ALU: add by default, shift-left for R-type fcode 4
    always_comb begin
        {alu_carry, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
        if (alu_opcode == 3'b000 && alu_fcode == 4'd4) {alu_carry, alu_out} = {1'b0, alu_in1 << alu_in2[4:0]};
        alu_zero = alu_out == 32'd0;
        alu_sign = alu_out[31];
    end

    task automatic issue(input logic [31:0] w);
        @(negedge clk);
        vec++;
        if (instr_ready !== 1'b1) begin miss++; $display("FAIL issue_ready: got %b want 1", instr_ready); end
        instr = w;
        instr_valid = 1;
        @(posedge clk);
        #1 instr_valid = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec++;
        if (instr_ready !== 1'b0) begin miss++; $display("FAIL rst_ready: got %b want 0", instr_ready); end
        vec++;
        if ({alu_opcode, alu_fcode, alu_in1, alu_in2, wb_en, wb_addr, wb_data, flags, branch_taken, branch_offset, illegal, trap} !== '0) begin
            miss++; $display("FAIL rst_outputs: got nonzero want all zero");
        end
        rst = 0;
        @(negedge clk);
        vec++;
        if (instr_ready !== 1'b1) begin miss++; $display("FAIL rst_release_ready: got %b want 1", instr_ready); end
    endtask

    task automatic test_add;
        issue(ADD);
        @(negedge clk);
        vec++;
        if ({instr_ready, rs_addr, rt_addr} !== {1'b0, 5'd1, 5'd2}) begin miss++; $display("FAIL add_decode: got %h want %h", {instr_ready, rs_addr, rt_addr}, {1'b0, 5'd1, 5'd2}); end
        @(negedge clk);
        vec++;
        if ({instr_ready, alu_opcode, alu_fcode, alu_in1, alu_in2} !== {1'b0, 3'd0, 4'd3, 32'd5, 32'd7}) begin
            miss++; $display("FAIL add_exec: in1 %h in2 %h fc %h want 5 7 3", alu_in1, alu_in2, alu_fcode);
        end
        @(negedge clk);
        vec++;
        if ({instr_ready, wb_en, wb_addr, wb_data, flags, branch_taken, illegal} !== {1'b0, 1'b1, 5'd1, 32'd12, 3'b000, 1'b0, 1'b0}) begin
            miss++; $display("FAIL add_wb: en %b addr %0d data %h flags %b want 1 1 c 000", wb_en, wb_addr, wb_data, flags);
        end
        @(negedge clk);
        vec++;
        if ({instr_ready, wb_en} !== 2'b10) begin miss++; $display("FAIL add_done: got %b want 10", {instr_ready, wb_en}); end
    endtask

    task automatic test_shift;
        issue(SHLL);
        repeat (2) @(negedge clk);
        vec++;
        if ({alu_in1, alu_in2} !== {32'd1, 32'd31}) begin miss++; $display("FAIL shift_operands: got %h %h want 1 1f", alu_in1, alu_in2); end
        @(negedge clk);
        vec++;
        if ({wb_en, wb_addr, wb_data, flags} !== {1'b1, 5'd3, 32'h8000_0000, 3'b001}) begin
            miss++; $display("FAIL shift_wb: en %b addr %0d data %h flags %b want 1 3 80000000 001", wb_en, wb_addr, wb_data, flags);
        end
    endtask

    task automatic test_imm;
        issue(ADDI);
        repeat (2) @(negedge clk);
        vec++;
        if ({alu_opcode, alu_in1, alu_in2} !== {3'b001, 32'd1, 32'hFFFF_FFFF}) begin miss++; $display("FAIL imm_operands: got %h %h want 1 ffffffff", alu_in1, alu_in2); end
        @(negedge clk);
        vec++;
        if ({wb_en, wb_addr, wb_data, flags} !== {1'b1, 5'd4, 32'd0, 3'b110}) begin
            miss++; $display("FAIL imm_wb: en %b addr %0d data %h flags %b want 1 4 0 110", wb_en, wb_addr, wb_data, flags);
        end
    endtask

    task automatic test_branch;
        issue(BZ);
        repeat (3) @(negedge clk);
        vec++;
        if ({branch_taken, branch_offset, wb_en, flags} !== {1'b1, 16'h0010, 1'b0, 3'b110}) begin
            miss++; $display("FAIL bz_wb: taken %b off %h en %b flags %b want 1 0010 0 110", branch_taken, branch_offset, wb_en, flags);
        end
        @(negedge clk);
        vec++;
        if (branch_taken !== 1'b0) begin miss++; $display("FAIL bz_pulse: got %b want 0", branch_taken); end
        issue(BNZ);
        repeat (3) @(negedge clk);
        vec++;
        if ({branch_taken, branch_offset, wb_en} !== {1'b0, 16'h0020, 1'b0}) begin
            miss++; $display("FAIL bnz_wb: taken %b off %h en %b want 0 0020 0", branch_taken, branch_offset, wb_en);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        instr = ADD;
        instr_valid = 1;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            vec++;
            if ({instr_ready, wb_en} !== {k == 4 || k == 8, k == 3 || k == 7}) begin
                miss++; $display("FAIL b2b_cycle%0d: ready/wb %b want %b", k, {instr_ready, wb_en}, {k == 4 || k == 8, k == 3 || k == 7});
            end
        end
        instr_valid = 0;
    endtask

    task automatic test_illegal;
        issue(BAD);
        @(negedge clk);
        vec++;
        if ({illegal, instr_ready, wb_en, branch_taken} !== 4'b1000) begin miss++; $display("FAIL illegal_pulse: got %b want 1000", {illegal, instr_ready, wb_en, branch_taken}); end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        repeat (3) begin
            @(negedge clk);
            vec++;
            if ({illegal, instr_ready, trap} !== 3'b001) begin miss++; $display("FAIL trap_hold: got %b want 001", {illegal, instr_ready, trap}); end
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        vec++;
        if ({instr_ready, trap} !== 2'b10) begin miss++; $display("FAIL trap_exit: got %b want 10", {instr_ready, trap}); end
`else
        @(negedge clk);
        vec++;
        if ({illegal, instr_ready, trap} !== 3'b010) begin miss++; $display("FAIL illegal_recover: got %b want 010", {illegal, instr_ready, trap}); end
        instr = ADD;
        instr_valid = 1;
        @(posedge clk);
        #1 instr_valid = 0;
        repeat (3) @(negedge clk);
        vec++;
        if ({wb_en, wb_data} !== {1'b1, 32'd12}) begin miss++; $display("FAIL illegal_next: en %b data %h want 1 c", wb_en, wb_data); end
`endif
    endtask

    task automatic test_reset_exec;
        issue(ADD);
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        vec++;
        if ({instr_ready, wb_en, branch_taken} !== 3'b000) begin miss++; $display("FAIL rstexec_abort: got %b want 000", {instr_ready, wb_en, branch_taken}); end
        vec++;
        if ({alu_opcode, alu_fcode, alu_in1, alu_in2, wb_en, wb_addr, wb_data, flags, branch_taken, branch_offset, illegal, trap} !== '0) begin
            miss++; $display("FAIL rstexec_outputs: got nonzero want all zero");
        end
        rst = 0;
        repeat (2) begin
            @(negedge clk);
            vec++;
            if ({instr_ready, wb_en} !== 2'b10) begin miss++; $display("FAIL rstexec_after: got %b want 10", {instr_ready, wb_en}); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 0;
        regs[1] = 5;
        regs[2] = 7;
        regs[3] = 1;
        regs[4] = 1;
        test_reset;
        test_add;
        test_shift;
        test_imm;
        test_branch;
        test_back_to_back;
        test_illegal;
        test_reset_exec;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/alu_issue_fsm.md
# alu_issue_fsm

Multi-cycle issue and sequencing controller on the initiator side of the KGP_RISC ALU. It accepts one 32-bit instruction at a time and reads the register file. It drives the ALU opcode, fcode and operand inputs, samples the combinational result and flags, then issues a register writeback or a branch decision. It sits between the fetch stage and the ALU/register file and is the sole driver of the ALU control inputs.

## Interface
- No parameters; widths are fixed at 32-bit data and 5-bit register addresses.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr` in 32: instruction word, valid with `instr_valid`.
- `instr_valid` in 1: fetch has an instruction.
- `instr_ready` out 1: block accepts `instr` this cycle.
- `rs_addr`, `rt_addr` out 5: register-file read addresses.
- `rs_data`, `rt_data` in 32: combinational register-file read data.
- `alu_opcode` out 3, `alu_fcode` out 4, `alu_in1` out 32, `alu_in2` out 32: ALU controls and operands, all registered.
- `alu_out` in 32; `alu_carry`, `alu_zero`, `alu_sign` in 1: ALU result and flags.
- `wb_en` out 1, `wb_addr` out 5, `wb_data` out 32: register writeback, one-cycle pulse.
- `flags` out 3: {carry, zero, sign}, the last arithmetic/logic flags.
- `branch_taken` out 1, `branch_offset` out 16: branch decision, one-cycle pulse.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `trap` out 1: sticky trap indicator (see Configuration).

## Operation
- Instruction fields:
  - opcode = instr[31:29]
  - rs = instr[28:24]
  - rt = instr[23:19]
  - shamt = instr[18:14]
  - imm16 = instr[19:4]
  - fcode = instr[3:0]
- FSM states: IDLE → DECODE → EXEC → WB → IDLE. TRAP exists only with the macro.
- IDLE: `instr_ready`=1. On `instr_valid`, latch `instr` and go to DECODE.
- DECODE: drive `rs_addr`/`rt_addr` and register the ALU operands.
  - R-type (opcode 000), fcode 0–3, 6, 7, 9: in1=rs_data, in2=rt_data.
  - R-type, fcode 4, 5, 8: in2={27'b0, shamt}.
  - I-type (opcode 001), fcode 0–1: in1=rs_data, in2=sign-extended imm16.
  - Branch (opcode 101), fcode 0–2: in1=rs_data, in2=0.
  - Any other opcode/fcode: illegal. Assert `illegal` and return to IDLE, or go to TRAP with the macro. Nothing is driven to the ALU.
- EXEC: ALU controls are stable. At the clock edge, sample `alu_out` and the flags.
- WB, R-type and I-type: `wb_en`=1, `wb_addr`=rs, `wb_data`=sampled `alu_out`. `flags` updates to the sampled {carry, zero, sign}.
- WB, branch: `branch_taken` is set as follows; `flags` does not change.
  - fcode 0 (bltz): sign.
  - fcode 1 (bz): zero.
  - fcode 2 (bnz): !zero.
- WB, branch: `branch_offset`=imm16 whether or not the branch is taken.
- Writes to r0 are not filtered here; the register file owns that.

## Timing
- Handshake: an instruction is accepted on the edge where `instr_valid && instr_ready`.
- Legal instructions:
  - DECODE is cycle +1, EXEC +2, WB +3.
  - `instr_ready` returns high at +4.
  - Throughput is one instruction per 4 cycles.
- Illegal instruction: `illegal` pulses in cycle +1. Without the macro, `instr_ready` is high again at +2.
- `instr_valid` held high during a busy state is ignored. It is not queued.
- Reset values (taking effect at the edge with `rst`=1):
  - state IDLE;
  - `alu_opcode`=0, `alu_fcode`=0, `alu_in1`=0, `alu_in2`=0;
  - `wb_en`=0, `branch_taken`=0, `illegal`=0, `trap`=0, `flags`=0;
  - `wb_addr`=0, `wb_data`=0, `branch_offset`=0.
- `instr_ready` is 0 while `rst`=1 and 1 in the first cycle after release.
- Reset in DECODE, EXEC or WB aborts the instruction. No `wb_en` or `branch_taken` pulse is issued after the reset edge.
- `wb_en`, `branch_taken` and `illegal` are never high together. Each is high for exactly one cycle.

## Configuration
- Macro: `ALU_ISSUE_ILLEGAL_TRAP_EN`.
- Defined: an illegal instruction goes to TRAP.
  - `trap`=1 sticky.
  - `instr_ready`=0.
  - Only `rst` exits TRAP.
- Undefined: an illegal instruction is dropped after the `illegal` pulse. `trap` is tied 0 and the TRAP state is not built.

## Test plan
- Add: r1=5, r2=7, instr add r1,r2 (000/0011) → at +3, `wb_en`=1, `wb_addr`=1, `wb_data`=12, `flags`=3'b000. `instr_ready` is 0 for cycles +1..+3.
- Shift: r3=0x0000_0001, shll r3 with shamt=31 → `alu_in2`=31, `wb_data`=0x8000_0000, `flags`=3'b001.
- Immediate: addi r4 with imm16=0xFFFF and r4=1 → `alu_in2`=0xFFFF_FFFF, `wb_data`=0, carry=1, `flags`=3'b110.
- Branch: bz r5 with r5=0, imm16=0x0010 → `branch_taken`=1, `branch_offset`=0x0010, `wb_en`=0, `flags` unchanged. bnz with r5=0 → `branch_taken`=0.
- Illegal: opcode 011 → `illegal` pulse at +1.
  - Without the macro: the next instruction is accepted at +2.
  - With the macro: `trap`=1 and `instr_ready`=0 until `rst`.
- Reset in EXEC during add → no `wb_en`; `instr_ready`=1 the cycle after `rst` falls; all outputs at their reset values.
